sa_sched: RTL and testbench
===========================

# sa_sched

Tile sequencer for the `SA_CORE` systolic array. It accepts one matrix-tile command at a time and generates skewed per-row operand-buffer reads with `inpvalid` for the array. It then waits for all row results to become valid and drains them with `outread` under a downstream ready handshake. It sits between the command/DMA front end and `SA_CORE`, and it owns every `inpvalid`/`outread` toggle of the core.

## Interface
Parameters:
- `ROWS`, default 8: array rows; number of operand lanes and result words per tile.
- `K_MAX`, default 256: maximum accumulation length per tile.
- `TIMEOUT`, default 1024: maximum drain-wait cycles before an error is flagged.
- Derived: `KW = $clog2(K_MAX+1)`, `AW = $clog2(K_MAX)`.

Ports:
- `clk`  in  1: clock, rising edge.
- `rstn`  in  1: reset; one clock; asynchronous, active-low.
- `cmd_valid`  in  1: command offered.
- `cmd_ready`  out  1: scheduler idle and able to accept a command.
- `cmd_klen`  in  KW: accumulation length; legal range 1..K_MAX.
- `lane_en`  out  ROWS: per-row operand buffer read enable (A and W buffers of row r).
- `lane_addr`  out  ROWS*AW: packed per-row read address; row r occupies bits [r*AW +: AW].
- `inpvalid`  out  1: to `SA_CORE`; operands on the core inputs are valid.
- `rvalid`  in  ROWS: from `SA_CORE` `rvalidport`, one bit per row.
- `outread`  out  1: to `SA_CORE`; pops one result word.
- `res_valid`  out  1: a result word is available downstream this cycle (equals `outread`).
- `res_ready`  in  1: downstream accepts a result word.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: single-cycle pulse on tile completion.
- `err`  out  1: single-cycle pulse on an illegal command or a drain timeout.

## Operation
- States: IDLE, FEED, WAIT, DRAIN.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid` with `cmd_klen` in 1..K_MAX: latch `klen`, clear `t`, go to FEED.
  - On `cmd_valid` with `cmd_klen`=0 or >K_MAX: pulse `err`, stay in IDLE, issue no reads.
- FEED:
  - `t` counts 0..klen+ROWS-2.
  - `lane_en[r] = (t >= r) && (t < klen + r)`.
  - `lane_addr[r] = t - r`, truncated to AW bits; the value is don't-care when `lane_en[r]`=0 but is driven to 0.
  - `inpvalid`=1 throughout FEED.
  - After the cycle with t = klen+ROWS-2, go to WAIT and clear the timeout counter.
- WAIT:
  - All outputs are idle; the timeout counter increments each cycle.
  - When `&rvalid`, go to DRAIN with the word counter `n`=0.
  - When the counter reaches TIMEOUT-1 first, pulse `err` and go to IDLE. `done` is not pulsed.
- DRAIN:
  - `outread = res_valid = res_ready && (&rvalid)`.
  - `n` increments on each `outread`.
  - The pop with n = ROWS-1 pulses `done` in the same cycle, and the next state is IDLE.
  - If `res_ready`=0, stall indefinitely: no timeout in DRAIN.
- `cmd_valid` is ignored outside IDLE. No command queueing.
- Arithmetic: `t` and `klen` are KW+1 bits wide so that klen+ROWS-2 does not overflow.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, `busy`=0, and every other output 0. All counters are 0.
- Command accepted at edge E0 (`cmd_valid & cmd_ready`): `busy`=1 and `inpvalid`=1 from E0 onward. The first FEED cycle is E0→E1.
- FEED lasts exactly klen+ROWS-1 cycles.
- WAIT lasts at least 1 cycle, even if `rvalid` is already all-ones.
- Best-case drain: ROWS consecutive cycles with `res_ready`=1.
- `done` coincides with the last `outread`. `cmd_ready` returns high the cycle after `done`.
- Minimum tile time: klen + 2*ROWS cycles from acceptance to `cmd_ready`.
- Reset asserted mid-tile: all outputs deassert asynchronously and the state returns to IDLE. There is no partial `done` or `err`.

## Test plan
- Reset, ROWS=8, klen=4, `rvalid`=8'hFF, `res_ready`=1:
  - FEED is 11 cycles.
  - `lane_en[0]` is high in FEED cycles 0-3 with addresses 0,1,2,3.
  - `lane_en[7]` is high in FEED cycles 7-10 with addresses 0..3.
  - Then 1 WAIT cycle, then 8 consecutive `outread` pulses, with `done` on the 8th.
- Drain backpressure: toggle `res_ready` 1,0,1,0 during DRAIN.
  - Exactly 8 `outread` pulses occur, only in `res_ready` cycles.
  - `done` fires on the 8th pulse, with no timeout.
- `cmd_klen`=0, then `cmd_klen`=K_MAX+1:
  - Each produces one `err` pulse, with `busy` staying 0 and `lane_en` staying 0.
- Timeout: `rvalid`=8'h7F held after FEED with TIMEOUT=16.
  - `err` pulses 16 cycles after WAIT entry, the scheduler returns to IDLE, and `outread` never asserts.
- Hold `cmd_valid`=1 with a new klen throughout a tile:
  - Exactly one command is accepted per tile, and the second is accepted on the cycle after `done`.
- Deassert `rstn` in the 5th FEED cycle of klen=K_MAX:
  - All outputs go to 0 immediately and `cmd_ready`=1.
  - After release, a klen=1 tile completes normally with FEED = ROWS cycles.

Source files
------------

// File: rtl/sa_sched.sv
// Tile sequencer for the SA_CORE systolic array: skewed per-row operand reads, result drain.
// Latency: operands start the cycle after command accept; tile takes >= klen + 2*ROWS cycles.
// Backpressure: one command at a time (cmd_ready only in IDLE); drain stalls on res_ready=0.
//
// Ports:
//   clk, rstn            clock, async active-low reset
//   cmd_valid/ready/klen tile command handshake, klen legal in 1..K_MAX
//   lane_en, lane_addr   per-row operand buffer read enable / packed address (row r at [r*AW +: AW])
//   inpvalid             operands valid at SA_CORE inputs (high for the whole feed phase)
//   rvalid               per-row result valid from SA_CORE
//   outread, res_valid   result pop to SA_CORE / result word offered downstream (identical)
//   res_ready            downstream accepts a result word
//   busy, done, err      not idle / tile-complete pulse / illegal command or drain-timeout pulse
module sa_sched #(
  parameter  int ROWS    = 8,
  parameter  int K_MAX   = 256,
  parameter  int TIMEOUT = 1024,
  localparam int KW      = $clog2(K_MAX + 1),
  localparam int AW      = $clog2(K_MAX)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [KW-1:0]      cmd_klen,
  output logic [ROWS-1:0]    lane_en,
  output logic [ROWS*AW-1:0] lane_addr,
  output logic               inpvalid,
  input  logic [ROWS-1:0]    rvalid,
  output logic               outread,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int TMW = $clog2(TIMEOUT + 1);
  localparam int NW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t         state;
  logic [KW:0]    t;      // one bit wider than klen so klen+ROWS-2 cannot wrap
  logic [KW:0]    klen;
  logic [TMW-1:0] tmo;
  logic [NW-1:0]  n;
  logic           err_q;

  logic cmd_legal;
  logic feed_last;
  logic pop;
  logic last_pop;

  assign cmd_legal = (cmd_klen != '0) && (32'(cmd_klen) <= 32'(K_MAX));
  assign feed_last = (32'(t) == 32'(klen) + 32'(ROWS) - 32'd2);
  assign pop       = (state == S_DRAIN) && res_ready && (&rvalid);
  assign last_pop  = pop && (32'(n) == 32'(ROWS - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      t     <= '0;
      klen  <= '0;
      tmo   <= '0;
      n     <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_legal) begin
              klen  <= {1'b0, cmd_klen};
              t     <= '0;
              state <= S_FEED;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_FEED: begin
          if (feed_last) begin
            tmo   <= '0;
            state <= S_WAIT;
          end else begin
            t <= t + 1'b1;
          end
        end
        S_WAIT: begin
          // All-rows-valid wins over a timeout landing in the same cycle.
          if (&rvalid) begin
            n     <= '0;
            state <= S_DRAIN;
          end else if (32'(tmo) == 32'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        S_DRAIN: begin
          if (pop) begin
            if (last_pop) state <= S_IDLE;
            else          n     <= n + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Row r sees the same operand stream as row 0, delayed by r cycles.
  always_comb begin
    lane_en   = '0;
    lane_addr = '0;
    if (state == S_FEED) begin
      for (int r = 0; r < ROWS; r++) begin
        if ((32'(t) >= 32'(r)) && (32'(t) < 32'(klen) + 32'(r))) begin
          lane_en[r]             = 1'b1;
          lane_addr[r*AW +: AW]  = AW'(32'(t) - 32'(r));
        end
      end
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign inpvalid  = (state == S_FEED);
  assign outread   = pop;
  assign res_valid = pop;
  assign done      = last_pop;
  assign err       = err_q;

endmodule

// File: tb/tb_sa_sched.sv
module tb_sa_sched;

  localparam int ROWS    = 8;
  localparam int K_MAX   = 256;
  localparam int TIMEOUT = 16;
  localparam int KW      = 9;
  localparam int AW      = 8;

  logic               clk;
  logic               rstn;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [KW-1:0]      cmd_klen;
  logic [ROWS-1:0]    lane_en;
  logic [ROWS*AW-1:0] lane_addr;
  logic               inpvalid;
  logic [ROWS-1:0]    rvalid;
  logic               outread;
  logic               res_valid;
  logic               res_ready;
  logic               busy;
  logic               done;
  logic               err;

  int n_assert;
  int n_fail;

  sa_sched #(.ROWS(ROWS), .K_MAX(K_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_klen  (cmd_klen),
    .lane_en   (lane_en),
    .lane_addr (lane_addr),
    .inpvalid  (inpvalid),
    .rvalid    (rvalid),
    .outread   (outread),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Walks the feed phase from its first cycle, checking every lane against the skew rule.
  task automatic feed_check(input int kl);
    int c;
    logic [ROWS-1:0]    e_en;
    logic [ROWS*AW-1:0] e_addr;
    c = 0;
    while (inpvalid === 1'b1 && c < 400) begin
      e_en   = '0;
      e_addr = '0;
      for (int r = 0; r < ROWS; r++) begin
        if (c >= r && c < kl + r) begin
          e_en[r]               = 1'b1;
          e_addr[r*AW +: AW]    = AW'(c - r);
        end
      end
      chk("feed_lane_en", 64'(lane_en), 64'(e_en));
      chk("feed_lane_addr", lane_addr, e_addr);
      chk("feed_busy", 64'(busy), 64'd1);
      chk("feed_cmd_ready", 64'(cmd_ready), 64'd0);
      cyc();
      c++;
    end
    chk("feed_len", 64'(c), 64'(kl + ROWS - 1));
  endtask

  // One WAIT cycle, then ROWS back-to-back pops with res_ready=1.
  task automatic drain_full();
    chk("wait_inpvalid", 64'(inpvalid), 64'd0);
    chk("wait_outread", 64'(outread), 64'd0);
    chk("wait_busy", 64'(busy), 64'd1);
    cyc();
    for (int i = 0; i < ROWS; i++) begin
      chk("drain_outread", 64'(outread), 64'd1);
      chk("drain_res_valid", 64'(res_valid), 64'd1);
      chk("drain_done", 64'(done), 64'(i == ROWS - 1));
      cyc();
    end
    chk("post_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_done", 64'(done), 64'd0);
  endtask

  initial begin
    int pulses;
    int w;
    n_assert  = 0;
    n_fail    = 0;
    rstn      = 1'b0;
    cmd_valid = 1'b0;
    cmd_klen  = '0;
    rvalid    = '0;
    res_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_lane_en", 64'(lane_en), 64'd0);
    chk("rst_lane_addr", lane_addr, 64'd0);
    chk("rst_inpvalid", 64'(inpvalid), 64'd0);
    chk("rst_outread", 64'(outread), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rstn = 1'b1;
    cyc();

    // Basic tile: klen=4, results ready, downstream always ready.
    cmd_valid = 1'b1;
    cmd_klen  = 9'd4;
    rvalid    = 8'hFF;
    res_ready = 1'b1;
    #1;
    chk("t1_cmd_ready", 64'(cmd_ready), 64'd1);
    cyc();
    cmd_valid = 1'b0;
    chk("t1_inpvalid_e0", 64'(inpvalid), 64'd1);
    feed_check(4);
    drain_full();

    // Drain backpressure: res_ready alternates 1,0,1,0...
    cmd_valid = 1'b1;
    cmd_klen  = 9'd2;
    cyc();
    cmd_valid = 1'b0;
    feed_check(2);
    chk("bp_wait_outread", 64'(outread), 64'd0);
    cyc();
    pulses = 0;
    w = 0;
    while (pulses < ROWS && w < 40) begin
      res_ready = ((w % 2) == 0);
      #1;
      chk("bp_outread", 64'(outread), 64'(res_ready));
      if (outread === 1'b1) begin
        pulses++;
        chk("bp_done", 64'(done), 64'(pulses == ROWS));
      end else begin
        chk("bp_done_idle", 64'(done), 64'd0);
      end
      chk("bp_err", 64'(err), 64'd0);
      cyc();
      w++;
    end
    chk("bp_pulses", 64'(pulses), 64'(ROWS));
    chk("bp_cycles", 64'(w), 64'(2 * ROWS - 1));
    chk("bp_cmd_ready", 64'(cmd_ready), 64'd1);
    res_ready = 1'b1;

    // Illegal commands: klen=0 then klen=K_MAX+1.
    cmd_valid = 1'b1;
    cmd_klen  = 9'd0;
    cyc();
    cmd_valid = 1'b0;
    chk("ill0_err", 64'(err), 64'd1);
    chk("ill0_busy", 64'(busy), 64'd0);
    chk("ill0_lane_en", 64'(lane_en), 64'd0);
    cyc();
    chk("ill0_err_clear", 64'(err), 64'd0);
    cmd_valid = 1'b1;
    cmd_klen  = 9'd257;
    cyc();
    cmd_valid = 1'b0;
    chk("ill257_err", 64'(err), 64'd1);
    chk("ill257_busy", 64'(busy), 64'd0);
    chk("ill257_lane_en", 64'(lane_en), 64'd0);
    chk("ill257_cmd_ready", 64'(cmd_ready), 64'd1);
    cyc();
    chk("ill257_err_clear", 64'(err), 64'd0);

    // Drain timeout: one row never becomes valid.
    rvalid    = 8'h7F;
    cmd_valid = 1'b1;
    cmd_klen  = 9'd1;
    cyc();
    cmd_valid = 1'b0;
    feed_check(1);
    w = 0;
    while (err !== 1'b1 && w < 40) begin
      chk("to_outread", 64'(outread), 64'd0);
      chk("to_done", 64'(done), 64'd0);
      cyc();
      w++;
    end
    chk("to_err_delay", 64'(w), 64'(TIMEOUT));
    chk("to_busy", 64'(busy), 64'd0);
    chk("to_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("to_outread_end", 64'(outread), 64'd0);
    chk("to_done_end", 64'(done), 64'd0);
    rvalid = 8'hFF;
    cyc();
    chk("to_err_clear", 64'(err), 64'd0);

    // cmd_valid held across a tile: the second command waits until after done.
    cmd_valid = 1'b1;
    cmd_klen  = 9'd3;
    #1;
    chk("hold_cmd_ready", 64'(cmd_ready), 64'd1);
    cyc();
    cmd_klen = 9'd5;
    feed_check(3);
    drain_full();
    cyc();
    cmd_valid = 1'b0;
    chk("hold_second_accept", 64'(inpvalid), 64'd1);
    feed_check(5);
    drain_full();

    // Reset in the 5th feed cycle of a klen=K_MAX tile.
    cmd_valid = 1'b1;
    cmd_klen  = 9'(K_MAX);
    cyc();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("mr_inpvalid", 64'(inpvalid), 64'd1);
    chk("mr_lane_en", 64'(lane_en), 64'h1F);
    rstn = 1'b0;
    #1;
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_inpvalid_off", 64'(inpvalid), 64'd0);
    chk("mr_lane_en_off", 64'(lane_en), 64'd0);
    chk("mr_lane_addr_off", lane_addr, 64'd0);
    chk("mr_outread", 64'(outread), 64'd0);
    chk("mr_done", 64'(done), 64'd0);
    chk("mr_err", 64'(err), 64'd0);
    chk("mr_cmd_ready", 64'(cmd_ready), 64'd1);
    cyc();
    rstn = 1'b1;
    cyc();
    chk("mr_err_after", 64'(err), 64'd0);
    cmd_valid = 1'b1;
    cmd_klen  = 9'd1;
    cyc();
    cmd_valid = 1'b0;
    feed_check(1);
    drain_full();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
